// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state encoding and result width.
package div_ctrl_pkg;

    localparam int unsigned DIV_RESULT_W = 64;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

endpackage

// File: rtl/div_ctrl_if.sv
// EX-stage <-> divider handshake bundle; master is the EX stage, slave is the divider.
interface div_ctrl_if #(
    parameter int unsigned DATA_W = 32
);

    logic                  start_i;
    logic                  signed_i;
    logic                  annul_i;
    logic [DATA_W-1:0]     dividend_i;
    logic [DATA_W-1:0]     divisor_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  stallreq_o;

    modport master (
        output start_i, signed_i, annul_i, dividend_i, divisor_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  start_i, signed_i, annul_i, dividend_i, divisor_i,
        output result_o, ready_o, stallreq_o
    );

endinterface

// File: rtl/div_ctrl_step.sv
// One restoring radix-2 iteration: shift in the next dividend bit, trial subtract, emit quotient bit.
module div_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic [DATA_W-1:0] i_quo,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_rem,
    output logic [DATA_W-1:0] o_quo
);

    logic [DATA_W:0]   w_shift;
    logic [DATA_W-1:0] w_sub;
    logic              w_borrow;

    // i_quo holds remaining dividend bits in its upper part and quotient bits in its lower part
    always_comb begin
        w_shift  = {i_rem, i_quo[DATA_W-1]};
        w_borrow = (w_shift < {1'b0, i_divisor});
        w_sub    = w_shift[DATA_W-1:0] - i_divisor;
        o_rem    = w_borrow ? w_shift[DATA_W-1:0] : w_sub;
        o_quo    = {i_quo[DATA_W-2:0], ~w_borrow};
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed/unsigned divider controller: FSM, iteration counter, sign correction, result registers.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    div_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    div_state_t          r_state;
    div_state_t          w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_divisor;
    logic                r_signed;
    logic                r_dvd_neg;
    logic                r_q_neg;
    logic [2*DATA_W-1:0] r_result;
    logic                r_ready;

    logic                w_dvd_neg;
    logic                w_dsr_neg;
    logic [DATA_W-1:0]   w_dvd_abs;
    logic [DATA_W-1:0]   w_dsr_abs;
    logic [DATA_W-1:0]   w_rem_nxt;
    logic [DATA_W-1:0]   w_quo_nxt;
    logic [DATA_W-1:0]   w_rem_fix;
    logic [DATA_W-1:0]   w_quo_fix;
    logic                w_last;

    div_step #(.DATA_W(DATA_W)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_nxt),
        .o_quo     (w_quo_nxt)
    );

    always_comb begin
        w_dvd_neg = bus.signed_i & bus.dividend_i[DATA_W-1];
        w_dsr_neg = bus.signed_i & bus.divisor_i[DATA_W-1];
        w_dvd_abs = w_dvd_neg ? (DATA_W'(0) - bus.dividend_i) : bus.dividend_i;
        w_dsr_abs = w_dsr_neg ? (DATA_W'(0) - bus.divisor_i) : bus.divisor_i;
        w_quo_fix = (r_signed & r_q_neg)   ? (DATA_W'(0) - r_quo) : r_quo;
        w_rem_fix = (r_signed & r_dvd_neg) ? (DATA_W'(0) - r_rem) : r_rem;
        w_last    = (r_cnt == CNT_W'(DATA_W - 1));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= DivFree;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.annul_i) begin
            w_next = DivFree;
        end else begin
            case (r_state)
                DivFree:   if (bus.start_i) w_next = (bus.divisor_i == '0) ? DivByZero : DivOn;
                DivByZero: w_next = DivEnd;
                DivOn:     if (w_last) w_next = DivEnd;
                DivEnd:    if (!bus.start_i) w_next = DivFree;
                default:   w_next = DivFree;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_signed  <= 1'b0;
            r_dvd_neg <= 1'b0;
            r_q_neg   <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else if (bus.annul_i) begin
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                DivFree: begin
                    r_ready <= 1'b0;
                    if (bus.start_i) begin
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        r_quo     <= w_dvd_abs;
                        r_divisor <= w_dsr_abs;
                        r_signed  <= bus.signed_i;
                        r_dvd_neg <= w_dvd_neg;
                        r_q_neg   <= w_dvd_neg ^ w_dsr_neg;
                    end
                end
                // zeroed partials make the DONE correction yield an all-zero result
                DivByZero: begin
                    r_rem <= '0;
                    r_quo <= '0;
                end
                DivOn: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                end
                DivEnd: begin
                    if (!bus.start_i) begin
                        r_ready <= 1'b0;
                    end else if (!r_ready) begin
                        r_result <= {w_rem_fix, w_quo_fix};
                        r_ready  <= 1'b1;
                    end
                end
                default: r_ready <= 1'b0;
            endcase
        end
    end

    assign bus.result_o   = r_result;
    assign bus.ready_o    = r_ready;
    assign bus.stallreq_o = bus.start_i & ~r_ready & ~bus.annul_i;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl: latency, signed/unsigned results, annul, async reset.
module tb_div_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    div_ctrl_if #(.DATA_W(32)) bus ();

    div_ctrl #(.DATA_W(32)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues a request before edge 0 and waits (bounded) for ready; start_i stays high on return.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, output int lat, output logic [63:0] res,
                          output bit stall_ok);
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.signed_i   = sgn;
        bus.annul_i    = 1'b0;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        #1;
        stall_ok = (bus.stallreq_o === 1'b1);
        lat = -1;
        res = '0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o === 1'b1) begin
                lat = k;
                res = bus.result_o;
                break;
            end
            if (disturb && k == 6) bus.start_i = 1'b1;
            if (bus.stallreq_o !== 1'b1) stall_ok = 1'b0;
            if (disturb && k == 5) begin
                bus.start_i    = 1'b0;
                bus.dividend_i = ~a;
                bus.divisor_i  = b + 32'd3;
                bus.signed_i   = ~sgn;
            end
        end
    endtask

    task automatic drop_start();
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.start_i    = 1'b0;
        bus.signed_i   = 1'b0;
        bus.annul_i    = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        #2;
        n_cmp++;
        if (bus.ready_o !== 1'b0) begin
            n_err++; $display("FAIL reset_ready: got %b expected 0", bus.ready_o);
        end
        n_cmp++;
        if (bus.result_o !== 64'h0) begin
            n_err++; $display("FAIL reset_result: got %h expected 0", bus.result_o);
        end
        n_cmp++;
        if (bus.stallreq_o !== 1'b0) begin
            n_err++; $display("FAIL reset_stall: got %b expected 0", bus.stallreq_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        int lat; logic [63:0] res; bit ok;
        do_div(1'b0, 32'd7, 32'd2, 1'b0, lat, res, ok);
        n_cmp++;
        if (lat !== 33) begin n_err++; $display("FAIL u7_2_latency: got %0d expected 33", lat); end
        n_cmp++;
        if (res !== 64'h00000001_00000003) begin
            n_err++; $display("FAIL u7_2_result: got %h expected 0000000100000003", res);
        end
        n_cmp++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL u7_2_stall_busy: got %b expected 1", ok); end
        n_cmp++;
        if (bus.stallreq_o !== 1'b0) begin
            n_err++; $display("FAIL u7_2_stall_done: got %b expected 0", bus.stallreq_o);
        end
        drop_start();
        n_cmp++;
        if (bus.ready_o !== 1'b0) begin
            n_err++; $display("FAIL u7_2_ready_drop: got %b expected 0", bus.ready_o);
        end
    endtask

    task automatic test_signed_neg();
        int lat; logic [63:0] res; bit ok;
        do_div(1'b1, 32'hFFFFFFF9, 32'h2, 1'b1, lat, res, ok);
        n_cmp++;
        if (lat !== 33) begin n_err++; $display("FAIL sneg_latency: got %0d expected 33", lat); end
        n_cmp++;
        if (res !== 64'hFFFFFFFF_FFFFFFFD) begin
            n_err++; $display("FAIL sneg_result: got %h expected FFFFFFFFFFFFFFFD", res);
        end
        drop_start();
    endtask

    task automatic test_byzero();
        int lat; logic [63:0] res; bit ok;
        do_div(1'b1, 32'd5, 32'd0, 1'b0, lat, res, ok);
        n_cmp++;
        if (lat !== 2) begin n_err++; $display("FAIL byzero_latency: got %0d expected 2", lat); end
        n_cmp++;
        if (res !== 64'h0) begin n_err++; $display("FAIL byzero_result: got %h expected 0", res); end
        n_cmp++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL byzero_stall: got %b expected 1", ok); end
        drop_start();
    endtask

    task automatic test_back_to_back();
        logic        sg [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] av [3] = '{32'd100, 32'hFFFFFFFF, 32'd7};
        logic [31:0] bv [3] = '{32'd7, 32'h10, 32'hFFFFFFFE};
        logic [63:0] ev [3] = '{64'h00000002_0000000E, 64'h0000000F_0FFFFFFF,
                                64'h00000001_FFFFFFFD};
        int lat; logic [63:0] res; bit ok;
        for (int i = 0; i < 3; i++) begin
            do_div(sg[i], av[i], bv[i], 1'b0, lat, res, ok);
            n_cmp++;
            if (lat !== 33) begin n_err++; $display("FAIL b2b%0d_latency: got %0d expected 33", i, lat); end
            n_cmp++;
            if (res !== ev[i]) begin
                n_err++; $display("FAIL b2b%0d_result: got %h expected %h", i, res, ev[i]);
            end
            drop_start();
        end
    endtask

    task automatic test_signed_min();
        int lat; logic [63:0] res; bit ok;
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, res, ok);
        n_cmp++;
        if (res !== 64'h00000000_80000000) begin
            n_err++; $display("FAIL smin_result: got %h expected 0000000080000000", res);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000000_80000000) begin
            n_err++; $display("FAIL smin_hold: got ready %b result %h expected 1 0000000080000000",
                              bus.ready_o, bus.result_o);
        end
        drop_start();
        n_cmp++;
        if (bus.ready_o !== 1'b0) begin
            n_err++; $display("FAIL smin_ready_drop: got %b expected 0", bus.ready_o);
        end
        n_cmp++;
        if (bus.result_o !== 64'h00000000_80000000) begin
            n_err++; $display("FAIL smin_result_kept: got %h expected 0000000080000000", bus.result_o);
        end
    endtask

    task automatic test_annul();
        int lat; logic [63:0] res; bit ok; bit seen_ready;
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.signed_i   = 1'b0;
        bus.dividend_i = 32'hFFFFFFFF;
        bus.divisor_i  = 32'h1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        #1;
        n_cmp++;
        if (bus.stallreq_o !== 1'b0) begin
            n_err++; $display("FAIL annul_stall: got %b expected 0", bus.stallreq_o);
        end
        seen_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bus.ready_o !== 1'b0) seen_ready = 1'b1;
        end
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.ready_o !== 1'b0) seen_ready = 1'b1;
        end
        n_cmp++;
        if (seen_ready !== 1'b0) begin
            n_err++; $display("FAIL annul_no_ready: got %b expected 0", seen_ready);
        end
        do_div(1'b0, 32'hFFFFFFFF, 32'h1, 1'b0, lat, res, ok);
        n_cmp++;
        if (lat !== 33) begin n_err++; $display("FAIL annul_fresh_latency: got %0d expected 33", lat); end
        n_cmp++;
        if (res !== 64'h00000000_FFFFFFFF) begin
            n_err++; $display("FAIL annul_fresh_result: got %h expected 00000000FFFFFFFF", res);
        end
        drop_start();
    endtask

    task automatic test_async_reset();
        int lat; logic [63:0] res; bit ok;
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.signed_i   = 1'b0;
        bus.dividend_i = 32'd1000;
        bus.divisor_i  = 32'd3;
        repeat (6) @(posedge clk);
        #2;
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        #1;
        n_cmp++;
        if (bus.result_o !== 64'h0) begin
            n_err++; $display("FAIL async_rst_result: got %h expected 0", bus.result_o);
        end
        n_cmp++;
        if (bus.ready_o !== 1'b0) begin
            n_err++; $display("FAIL async_rst_ready: got %b expected 0", bus.ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_div(1'b0, 32'd9, 32'd3, 1'b0, lat, res, ok);
        n_cmp++;
        if (lat !== 33) begin n_err++; $display("FAIL post_rst_latency: got %0d expected 33", lat); end
        n_cmp++;
        if (res !== 64'h00000000_00000003) begin
            n_err++; $display("FAIL post_rst_result: got %h expected 0000000000000003", res);
        end
        drop_start();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed_neg();
        test_byzero();
        test_back_to_back();
        test_signed_min();
        test_annul();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter: DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
REQ-002 Clock and reset: one clock and one reset; reset is asynchronous and active-low.
REQ-003 clk_i  input  1  clock; all state changes on its rising edge.
REQ-004 rst_n_i  input  1  asynchronous active-low reset.
REQ-005 start_i  input  1  division request from EX; held high by EX until ready_o is seen.
REQ-006 signed_i  input  1  1 = DIV (two's complement), 0 = DIVU; sampled when a request is accepted.
REQ-007 annul_i  input  1  flush/exception cancel; aborts any operation in progress.
REQ-008 dividend_i  input  DATA_W  dividend; sampled when a request is accepted.
REQ-009 divisor_i  input  DATA_W  divisor; sampled when a request is accepted.
REQ-010 result_o  output  2*DATA_W  {remainder, quotient}; remainder in the upper half, destined for HI/LO.
REQ-011 ready_o  output  1  result_o valid.
REQ-012 stallreq_o  output  1  pipeline stall request to the stage controller.

Function
REQ-013 States: IDLE, BYZERO, RUN, DONE.
REQ-014 IDLE: start_i=1 and annul_i=0 accepts a request: operands and signed_i are latched, the iteration counter is cleared, and the next state is BYZERO if divisor_i==0, else RUN.
REQ-015 Signed operands: the absolute values of both operands are latched; the sign of the dividend and the XOR of the two operand signs are latched for correction.
REQ-016 RUN: one restoring radix-2 step per cycle.
- Step: trial subtract of the divisor from the partial remainder, shift, quotient bit = not borrow.
- Exactly DATA_W steps, counter 0..DATA_W-1, then DONE.
REQ-017 BYZERO: one cycle, then DONE with result forced to all zeros.
REQ-018 DONE (signed mode) on entry:
- quotient is negated when the operand signs differ;
- remainder takes the sign of the dividend;
- arithmetic wraps mod 2^DATA_W, so 0x80000000/0xFFFFFFFF gives quotient 0x80000000, remainder 0.
REQ-019 DONE: result_o and ready_o are registered; ready_o=1 and result_o stays stable while start_i=1; start_i=0 returns to IDLE with ready_o=0 the next cycle.
REQ-020 Latency: ready_o rises DATA_W+1 rising edges after acceptance (33 for DATA_W=32), or 2 edges for a zero divisor.
REQ-021 stallreq_o = start_i & ~ready_o & ~annul_i (combinational).
REQ-022 annul_i=1 in any state forces IDLE at the next edge with ready_o=0; a request presented together with annul_i is not accepted.
REQ-023 In RUN, start_i changes and operand input changes have no effect; only annul_i aborts.
REQ-024 result_o holds its last value outside DONE; consumers qualify it with ready_o.

Reset
REQ-025 rst_n_i=0 immediately forces IDLE, ready_o=0, result_o=0, counter=0, and all latched operand and sign registers to 0, independent of clk_i.
REQ-026 Reset deassertion mid-operation resumes from IDLE; no partial result is ever presented.

Structure
REQ-027 The shared defines package holds:
- the state enum typedef (div_state_t);
- the constants DivFree, DivByZero, DivOn, DivEnd;
- DIV_RESULT_W = 64.
REQ-028 One combinational sub-module, div_step, performs a single subtract-shift iteration; div_ctrl owns the FSM, counter, sign handling and registers.

Verification
REQ-029 Unsigned 7/2, start held: ready_o at edge 33; result_o = {32'h1, 32'h3}; stallreq_o high for edges 0-32.
REQ-030 Signed -7/2 (0xFFFFFFF9/0x2): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-031 Signed 5/0: BYZERO path; ready_o at edge 2; result_o = 64'h0.
REQ-032 Unsigned 0xFFFFFFFF/1, annul_i pulsed at edge 10: IDLE next cycle, ready_o never asserted, stallreq_o low; a fresh request then completes with quotient 0xFFFFFFFF, remainder 0.
REQ-033 Signed 0x80000000/0xFFFFFFFF: quotient 0x80000000, remainder 0; start_i dropped one cycle after ready_o gives ready_o=0 and IDLE next edge.
REQ-034 rst_n_i asserted asynchronously mid-RUN: outputs zero without waiting for a clock edge; a subsequent 9/3 request gives {0, 3}.
